// File: rtl/tsc_pkg.sv
// Shared widths and types for the transform shift calculator.
package tsc_pkg;

  localparam int unsigned BIT_DEPTH_W = 4;
  localparam int unsigned TR_SIZE_W   = 3;
  localparam int unsigned DYN_RANGE_W = 5;
  localparam int unsigned SHIFT_W     = 6;
  // One bit wider than the result so range - depth - size cannot overflow.
  localparam int unsigned RAW_W       = 7;

  typedef logic signed [SHIFT_W-1:0] tsc_shift_t;

endpackage

// File: rtl/tsc_shift_core.sv
// Combinational transform shift: range - depth - size, floored at zero when
// transform skip and extended precision are both enabled.
module tsc_shift_core
  import tsc_pkg::*;
(
  input  logic [BIT_DEPTH_W-1:0] i_channel_bit_depth,
  input  logic [TR_SIZE_W-1:0]   i_log2_tr_size,
  input  logic [DYN_RANGE_W-1:0] i_max_log2_tr_dynamic_range,
  input  logic                   i_clamp,
  output tsc_shift_t             o_shift
);

  logic signed [RAW_W-1:0] w_raw;

  assign w_raw = $signed({2'b00, i_max_log2_tr_dynamic_range})
               - $signed({3'b000, i_channel_bit_depth})
               - $signed({4'b0000, i_log2_tr_size});

  // Raw range is -22..31, so dropping the top bit is lossless.
  always_comb begin
    o_shift = w_raw[SHIFT_W-1:0];
    if (i_clamp && w_raw[RAW_W-1]) begin
      o_shift = '0;
    end
  end

endmodule

// File: rtl/transform_shift_calculator.sv
// Registered transform shift: one result per accepted input, 1-cycle latency,
// result held while no input is accepted.
module transform_shift_calculator
  import tsc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [BIT_DEPTH_W-1:0] channel_bit_depth,
  input  logic [TR_SIZE_W-1:0]   log2_tr_size,
  input  logic [DYN_RANGE_W-1:0] max_log2_tr_dynamic_range,
  input  logic                   use_transform_skip,
  input  logic                   extended_precision_processing,
  output logic                   out_valid,
  output tsc_shift_t             i_transform_shift
);

  logic       w_clamp;
  tsc_shift_t w_shift;

  logic       r_valid;
  logic       r_clamp;
  tsc_shift_t r_shift;

  assign w_clamp = use_transform_skip & extended_precision_processing;

  tsc_shift_core u_core (
    .i_channel_bit_depth         (channel_bit_depth),
    .i_log2_tr_size              (log2_tr_size),
    .i_max_log2_tr_dynamic_range (max_log2_tr_dynamic_range),
    .i_clamp                     (w_clamp),
    .o_shift                     (w_shift)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_clamp <= 1'b0;
      r_shift <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_clamp <= w_clamp;
        r_shift <= w_shift;
      end
    end
  end

  assign out_valid         = r_valid;
  assign i_transform_shift = r_shift;

  // A clamped result can never be negative.
  a_clamp_nonneg : assert property (
    @(posedge clk) disable iff (!rst_n) r_clamp |-> (i_transform_shift >= 0)
  );

endmodule

// File: tb/tb_transform_shift_calculator.sv
// Randomised scoreboard bench for transform_shift_calculator.
module tb_transform_shift_calculator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] depth = '0;
  logic [2:0] size = '0;
  logic [4:0] range = '0;
  logic       ts = 1'b0;
  logic       ep = 1'b0;
  logic       out_valid;
  logic signed [5:0] shift;

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   last_val = 0;

  transform_shift_calculator dut (
    .clk                           (clk),
    .rst_n                         (rst_n),
    .in_valid                      (in_valid),
    .channel_bit_depth             (depth),
    .log2_tr_size                  (size),
    .max_log2_tr_dynamic_range     (range),
    .use_transform_skip            (ts),
    .extended_precision_processing (ep),
    .out_valid                     (out_valid),
    .i_transform_shift             (shift)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic int model(input int d, input int s, input int r, input bit t, input bit e);
    int v;
    v = r - d - s;
    if (t && e && v < 0) v = 0;
    return v;
  endfunction

  // Drive one cycle of stimulus just after a rising edge.
  task automatic apply(input bit v, input int d, input int s, input int r,
                       input bit t, input bit e);
    exp_t x;
    @(posedge clk);
    #1;
    in_valid = v;
    depth = 4'(d);
    size = 3'(s);
    range = 5'(r);
    ts = t;
    ep = e;
    if (v) begin
      x.val = model(d, s, r, t, e);
      x.due = cyc + 1;
      q.push_back(x);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents a result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          exp_t x;
          x = q.pop_front();
          chk("shift", int'(shift), x.val);
          chk("latency", cyc, x.due);
          last_val = x.val;
        end
      end else begin
        if (q.size() != 0 && q[0].due <= cyc) chk("missing_out_valid", 0, 1);
        chk("hold", int'(shift), last_val);
      end
    end
  end

  initial begin
    #12;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_shift", int'(shift), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed vectors
    apply(1, 8, 2, 15, 0, 0);
    apply(1, 12, 5, 15, 0, 1);
    apply(1, 12, 5, 15, 1, 1);
    apply(1, 12, 5, 15, 1, 0);
    apply(1, 0, 0, 31, 0, 0);
    apply(1, 15, 7, 0, 0, 0);
    apply(1, 15, 7, 0, 1, 1);
    apply(0, 3, 1, 9, 1, 1);
    apply(0, 9, 6, 2, 0, 0);
    apply(1, 1, 1, 20, 0, 0);
    apply(1, 10, 4, 5, 0, 1);
    apply(1, 4, 3, 30, 1, 1);
    apply(0, 0, 0, 0, 0, 0);

    // Randomised stream with occasional gaps
    for (int i = 0; i < 300; i++) begin
      apply(($urandom_range(0, 3) != 0), $urandom_range(0, 15), $urandom_range(0, 7),
            $urandom_range(0, 31), 1'($urandom), 1'($urandom));
    end

    // Reset mid-stream with a result in flight
    apply(1, 2, 1, 20, 0, 0);
    apply(1, 5, 2, 3, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", int'(out_valid), 0);
    chk("async_reset_shift", int'(shift), 0);
    q.delete();
    last_val = 0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("post_reset_out_valid", int'(out_valid), 0);
    apply(1, 8, 2, 15, 0, 0);
    apply(1, 15, 7, 0, 1, 0);
    apply(0, 0, 0, 0, 0, 0);

    // Drain with a bounded wait
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    chk("drain_queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
